// File: rtl/traffic_pkg.sv
// Shared types and constants for the multi-side-road traffic controller.
package traffic_pkg;

    // Controller states; the numeric codes are visible on state_out.
    typedef enum logic [2:0] {
        MG_START = 3'd0,
        MG_CONT  = 3'd1,
        M_YEL    = 3'd2,
        ALL_RED  = 3'd3,
        WALK     = 3'd4,
        SG_START = 3'd5,
        SG_CONT  = 3'd6,
        S_YEL    = 3'd7
    } state_t;

    // Lamp encodings, {R,Y,G}.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic WALK_ON  = 1'b1;
    localparam logic WALK_OFF = 1'b0;

    // Width of a side-road index; at least one bit even for a single side.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/interval_timer.sv
// Interval down-counter. A load takes priority over counting; the
// count freezes while tick_en is low and never goes below 1, so
// "tick with count==1" marks the last tick of an interval.
module interval_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_tick_en,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_count;

    // Expiry is the tick that lands on the final count of the interval.
    assign o_expired = i_tick_en && (r_count == CNT_W'(1));

    // Count register: load on request, otherwise decrement on each tick above 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= RST_VAL;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_tick_en && (r_count > CNT_W'(1))) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_fsm_multi.sv
// Traffic controller for one main road and N_SIDE side roads with
// round-robin side service, pedestrian walk phase, all-red clearance
// and rest-in-main-green. Lamps are decoded from the state register.
module traffic_fsm_multi
    import traffic_pkg::*;
#(
    parameter int N_SIDE = 2,
    parameter int CNT_W  = 8,
    parameter int T_BASE = 6,
    parameter int T_EXT  = 3,
    parameter int T_YEL  = 2,
    parameter int T_CLR  = 1,
    parameter int T_WALK = 3
) (
    input  logic                        clk,
    input  logic                        sys_reset_n,
    input  logic                        tick_en,
    input  logic                        prg_sync_in,
    input  logic                        main_sensor_in,
    input  logic [N_SIDE-1:0]           sensor_sync_in,
    input  logic                        walk_btn_in,
    output logic [2:0]                  main_light,
    output logic [3*N_SIDE-1:0]         side_light,
    output logic                        walk_light,
    output logic                        walk_reset,
    output logic [sel_w(N_SIDE)-1:0]    serving_side,
    output logic [2:0]                  state_out
);

    localparam int SS_W = sel_w(N_SIDE);

    localparam logic [CNT_W-1:0] C_BASE = CNT_W'(T_BASE);
    localparam logic [CNT_W-1:0] C_EXT  = CNT_W'(T_EXT);
    localparam logic [CNT_W-1:0] C_YEL  = CNT_W'(T_YEL);
    localparam logic [CNT_W-1:0] C_CLR  = CNT_W'(T_CLR);
    localparam logic [CNT_W-1:0] C_WALK = CNT_W'(T_WALK);

    // Registered state and latches
    state_t            r_state;
    logic [N_SIDE-1:0] r_side_req;
    logic              r_walk_req;
    logic [SS_W-1:0]   r_rr_ptr;
    logic [SS_W-1:0]   r_serving_side;
    logic              r_dst_main;   // ALL_RED exit target: 1 = back to main green

    // Combinational controls
    state_t            w_next_state;
    logic              w_expired;
    logic              w_load;
    logic [CNT_W-1:0]  w_load_val;
    logic              w_dst_main_nxt;
    logic              w_sg_entry;
    logic              w_walk_done;
    logic [SS_W-1:0]   w_grant;
    logic              w_found;
    logic [SS_W-1:0]   w_idx;
    logic              w_any_side;
    logic [N_SIDE-1:0] w_clr_mask;

    assign w_any_side   = |r_side_req;
    assign state_out    = r_state;
    assign serving_side = r_serving_side;
    assign walk_reset   = w_walk_done;

    interval_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (C_BASE)
    ) u_timer (
        .clk       (clk),
        .rst_n     (sys_reset_n),
        .i_tick_en (tick_en),
        .i_load    (w_load),
        .i_value   (w_load_val),
        .o_expired (w_expired)
    );

    // Round-robin grant: first pending side after the last one granted.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N_SIDE; k++) begin
            w_idx = SS_W'((int'(r_rr_ptr) + k) % N_SIDE);
            if (!w_found && r_side_req[w_idx]) begin
                w_grant = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // Request bit to drop when the granted side enters its green.
    always_comb begin
        w_clr_mask = '0;
        if (w_sg_entry) begin
            w_clr_mask[w_grant] = 1'b1;
        end
    end

    // Next-state and interval selection; transitions only happen on expiry.
    always_comb begin
        w_next_state   = r_state;
        w_load         = 1'b0;
        w_load_val     = C_BASE;
        w_dst_main_nxt = r_dst_main;
        w_sg_entry     = 1'b0;
        w_walk_done    = 1'b0;
        if (prg_sync_in) begin
            w_next_state = MG_START;
            w_load       = 1'b1;
            w_load_val   = C_BASE;
        end else if (w_expired) begin
            w_load = 1'b1;
            case (r_state)
                MG_START: begin
                    w_next_state = MG_CONT;
                    w_load_val   = main_sensor_in ? C_EXT : C_BASE;
                end
                MG_CONT: begin
                    if (w_any_side || r_walk_req) begin
                        w_next_state = M_YEL;
                        w_load_val   = C_YEL;
                    end else begin
                        w_next_state = MG_CONT;   // rest in main green
                        w_load_val   = C_BASE;
                    end
                end
                M_YEL: begin
                    w_next_state   = ALL_RED;
                    w_load_val     = C_CLR;
                    w_dst_main_nxt = 1'b0;
                end
                ALL_RED: begin
                    if (r_dst_main) begin
                        w_next_state = MG_START;
                        w_load_val   = C_BASE;
                    end else if (r_walk_req) begin
                        w_next_state = WALK;
                        w_load_val   = C_WALK;
                    end else if (w_any_side) begin
                        w_next_state = SG_START;
                        w_load_val   = C_BASE;
                        w_sg_entry   = 1'b1;
                    end else begin
                        w_next_state = MG_START;
                        w_load_val   = C_BASE;
                    end
                end
                WALK: begin
                    w_walk_done = 1'b1;
                    w_load_val  = C_BASE;
                    if (w_any_side) begin
                        w_next_state = SG_START;
                        w_sg_entry   = 1'b1;
                    end else begin
                        w_next_state = MG_START;
                    end
                end
                SG_START: begin
                    if (sensor_sync_in[r_serving_side]) begin
                        w_next_state = SG_CONT;
                        w_load_val   = C_EXT;
                    end else begin
                        w_next_state = S_YEL;
                        w_load_val   = C_YEL;
                    end
                end
                SG_CONT: begin
                    w_next_state = S_YEL;
                    w_load_val   = C_YEL;
                end
                S_YEL: begin
                    w_next_state   = ALL_RED;
                    w_load_val     = C_CLR;
                    w_dst_main_nxt = 1'b1;
                end
                default: begin
                    w_next_state = MG_START;
                    w_load_val   = C_BASE;
                end
            endcase
        end
    end

    // State register and request latches; sets win over clears.
    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_state        <= MG_START;
            r_side_req     <= '0;
            r_walk_req     <= 1'b0;
            r_rr_ptr       <= SS_W'(N_SIDE - 1);
            r_serving_side <= '0;
            r_dst_main     <= 1'b0;
        end else if (prg_sync_in) begin
            r_state        <= MG_START;
            r_side_req     <= '0;
            r_walk_req     <= 1'b0;
            r_rr_ptr       <= SS_W'(N_SIDE - 1);
            r_serving_side <= '0;
            r_dst_main     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_dst_main <= w_dst_main_nxt;
            r_side_req <= (r_side_req & ~w_clr_mask) | sensor_sync_in;
            r_walk_req <= (r_walk_req & ~w_walk_done) | walk_btn_in;
            if (w_sg_entry) begin
                r_rr_ptr       <= w_grant;
                r_serving_side <= w_grant;
            end
        end
    end

    // Moore lamp decode from the state register.
    always_comb begin
        main_light = RED;
        side_light = {N_SIDE{RED}};
        walk_light = WALK_OFF;
        case (r_state)
            MG_START, MG_CONT: main_light = GRN;
            M_YEL:             main_light = YEL;
            WALK:              walk_light = WALK_ON;
            SG_START, SG_CONT: begin
                for (int i = 0; i < N_SIDE; i++) begin
                    if (SS_W'(i) == r_serving_side) begin
                        side_light[3*i +: 3] = GRN;
                    end
                end
            end
            S_YEL: begin
                for (int i = 0; i < N_SIDE; i++) begin
                    if (SS_W'(i) == r_serving_side) begin
                        side_light[3*i +: 3] = YEL;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_fsm_multi.sv
// Bench for traffic_fsm_multi: directed scenarios followed by random
// traffic, every cycle compared with a phase/tick reference model.
module tb_traffic_fsm_multi;

  localparam int N_SIDE = 2;
  localparam int T_BASE = 6;
  localparam int T_EXT  = 3;
  localparam int T_YEL  = 2;
  localparam int T_CLR  = 1;
  localparam int T_WALK = 3;
  localparam int SS_W   = 1;

  // Phase numbers as listed for state_out
  localparam int P_MGS = 0, P_MGC = 1, P_MY = 2, P_AR = 3;
  localparam int P_WK = 4, P_SGS = 5, P_SGC = 6, P_SY = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              sys_reset_n;
  logic              tick_en;
  logic              prg_sync_in;
  logic              main_sensor_in;
  logic [N_SIDE-1:0] sensor_sync_in;
  logic              walk_btn_in;
  logic [2:0]        main_light;
  logic [3*N_SIDE-1:0] side_light;
  logic              walk_light;
  logic              walk_reset;
  logic [SS_W-1:0]   serving_side;
  logic [2:0]        state_out;

  traffic_fsm_multi #(
    .N_SIDE (N_SIDE), .CNT_W (8), .T_BASE (T_BASE), .T_EXT (T_EXT),
    .T_YEL (T_YEL), .T_CLR (T_CLR), .T_WALK (T_WALK)
  ) dut (
    .clk            (clk),
    .sys_reset_n    (sys_reset_n),
    .tick_en        (tick_en),
    .prg_sync_in    (prg_sync_in),
    .main_sensor_in (main_sensor_in),
    .sensor_sync_in (sensor_sync_in),
    .walk_btn_in    (walk_btn_in),
    .main_light     (main_light),
    .side_light     (side_light),
    .walk_light     (walk_light),
    .walk_reset     (walk_reset),
    .serving_side   (serving_side),
    .state_out      (state_out)
  );

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- reference model ----------------
  // Phase number, its duration in ticks and ticks already spent in it.
  int m_ph, m_dur, m_done;
  bit m_req [N_SIDE];
  bit m_walk;
  int m_last;
  int m_serve;
  bit m_to_main;

  task automatic model_reset();
    m_ph = P_MGS; m_dur = T_BASE; m_done = 0;
    for (int i = 0; i < N_SIDE; i++) m_req[i] = 1'b0;
    m_walk = 1'b0; m_last = N_SIDE - 1; m_serve = 0; m_to_main = 1'b0;
  endtask

  function automatic int pick();
    for (int k = 1; k <= N_SIDE; k++)
      if (m_req[(m_last + k) % N_SIDE]) return (m_last + k) % N_SIDE;
    return -1;
  endfunction

  function automatic bit last_tick(input logic tk);
    return tk && (m_done + 1 == m_dur);
  endfunction

  task automatic model_step(input logic tk, input logic prg, input logic ms,
                            input logic [N_SIDE-1:0] ss, input logic wb);
    int g, nph, ndur;
    bit enter_sg, walk_fin, any_req;
    if (prg) begin
      model_reset();
      return;
    end
    g = pick();
    any_req = (g >= 0);
    nph = m_ph; ndur = m_dur; enter_sg = 1'b0; walk_fin = 1'b0;
    if (last_tick(tk)) begin
      case (m_ph)
        P_MGS: begin nph = P_MGC; ndur = ms ? T_EXT : T_BASE; end
        P_MGC: if (any_req || m_walk) begin nph = P_MY; ndur = T_YEL; end
               else begin nph = P_MGC; ndur = T_BASE; end
        P_MY:  begin nph = P_AR; ndur = T_CLR; m_to_main = 1'b0; end
        P_AR:  if (m_to_main) begin nph = P_MGS; ndur = T_BASE; end
               else if (m_walk) begin nph = P_WK; ndur = T_WALK; end
               else if (any_req) begin nph = P_SGS; ndur = T_BASE; enter_sg = 1'b1; end
               else begin nph = P_MGS; ndur = T_BASE; end
        P_WK:  begin
                 walk_fin = 1'b1; ndur = T_BASE;
                 if (any_req) begin nph = P_SGS; enter_sg = 1'b1; end
                 else nph = P_MGS;
               end
        P_SGS: if (ss[m_serve]) begin nph = P_SGC; ndur = T_EXT; end
               else begin nph = P_SY; ndur = T_YEL; end
        P_SGC: begin nph = P_SY; ndur = T_YEL; end
        P_SY:  begin nph = P_AR; ndur = T_CLR; m_to_main = 1'b1; end
        default: ;
      endcase
      m_ph = nph; m_dur = ndur; m_done = 0;
    end else if (tk) begin
      m_done++;
    end
    if (enter_sg) begin m_req[g] = 1'b0; m_last = g; m_serve = g; end
    for (int i = 0; i < N_SIDE; i++) if (ss[i]) m_req[i] = 1'b1;
    if (walk_fin) m_walk = 1'b0;
    if (wb) m_walk = 1'b1;
  endtask

  function automatic logic [2:0] exp_main();
    if (m_ph == P_MGS || m_ph == P_MGC) return 3'b001;
    if (m_ph == P_MY) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [3*N_SIDE-1:0] exp_side();
    logic [3*N_SIDE-1:0] v;
    for (int i = 0; i < N_SIDE; i++) begin
      v[3*i +: 3] = 3'b100;
      if (i == m_serve && (m_ph == P_SGS || m_ph == P_SGC)) v[3*i +: 3] = 3'b001;
      if (i == m_serve && m_ph == P_SY) v[3*i +: 3] = 3'b010;
    end
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_outputs(input logic tk, input logic prg);
    chk("state_out",    32'(state_out),    32'(m_ph));
    chk("main_light",   32'(main_light),   32'(exp_main()));
    chk("side_light",   32'(side_light),   32'(exp_side()));
    chk("walk_light",   32'(walk_light),   32'(m_ph == P_WK));
    chk("serving_side", 32'(serving_side), 32'(m_serve));
    chk("walk_reset",   32'(walk_reset),   32'(!prg && m_ph == P_WK && last_tick(tk)));
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the next falling edge.
  task automatic run_cycle(input logic tk, input logic prg, input logic ms,
                           input logic [N_SIDE-1:0] ss, input logic wb);
    tick_en = tk; prg_sync_in = prg; main_sensor_in = ms;
    sensor_sync_in = ss; walk_btn_in = wb;
    #1;
    check_outputs(tk, prg);
    @(posedge clk);
    model_step(tk, prg, ms, ss, wb);
    @(negedge clk);
  endtask

  logic [SS_W-1:0] exp_q[$];

  initial begin
    logic [2:0] prev;
    int cnt_my, cnt_sgs, cnt_sy, cnt_ar, cnt_g1, cnt_walk, cnt_wr;
    bit reached;

    // Reset
    sys_reset_n = 1'b0; tick_en = 1'b0; prg_sync_in = 1'b0; main_sensor_in = 1'b0;
    sensor_sync_in = '0; walk_btn_in = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_outputs(1'b0, 1'b0);
    @(negedge clk);
    sys_reset_n = 1'b1;

    // 1: idle rests in main green
    for (int c = 0; c < 40; c++) begin
      run_cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      chk("t1_main_green", 32'(main_light), 32'h1);
    end

    // 2: single side-1 request, one full service
    repeat (9) run_cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    cnt_my = 0; cnt_sgs = 0; cnt_sy = 0; cnt_ar = 0; cnt_g1 = 0;
    for (int c = 0; c < 60; c++) begin
      run_cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      if (state_out == 3'd2) cnt_my++;
      if (state_out == 3'd5) cnt_sgs++;
      if (state_out == 3'd7) cnt_sy++;
      if (state_out == 3'd3) cnt_ar++;
      if (side_light[5:3] == 3'b001) cnt_g1++;
    end
    chk("t2_m_yel_len",    32'(cnt_my),  32'd2);
    chk("t2_sg_start_len", 32'(cnt_sgs), 32'd6);
    chk("t2_s_yel_len",    32'(cnt_sy),  32'd2);
    chk("t2_all_red_len",  32'(cnt_ar),  32'd2);
    chk("t2_side1_green",  32'(cnt_g1),  32'd6);

    // 3: both sides held, served alternately
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    prev = state_out;
    for (int c = 0; c < 150 && exp_q.size() > 0; c++) begin
      run_cycle(1'b1, 1'b0, 1'b0, 2'b11, 1'b0);
      if (state_out == 3'd5 && prev != 3'd5) chk("t3_rr_order", 32'(serving_side), 32'(exp_q.pop_front()));
      prev = state_out;
    end
    chk("t3_all_served", 32'(exp_q.size()), 32'd0);
    repeat (120) run_cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);

    // 4: walk request with side-0 demand
    run_cycle(1'b1, 1'b0, 1'b0, 2'b01, 1'b1);
    cnt_walk = 0; cnt_wr = 0; prev = state_out;
    for (int c = 0; c < 100; c++) begin
      run_cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      if (walk_light) cnt_walk++;
      if (walk_reset) cnt_wr++;
      if (prev == 3'd4 && state_out != 3'd4) chk("t4_walk_to_sg", 32'(state_out), 32'd5);
      prev = state_out;
    end
    chk("t4_walk_len",    32'(cnt_walk), 32'd3);
    chk("t4_walk_pulses", 32'(cnt_wr),   32'd1);

    // 5: reprogram during SG_CONT
    reached = 1'b0;
    for (int c = 0; c < 120; c++) begin
      run_cycle(1'b1, 1'b0, 1'b0, 2'b11, 1'b0);
      if (state_out == 3'd6) begin reached = 1'b1; break; end
    end
    chk("t5_reach_sg_cont", 32'(reached), 32'd1);
    run_cycle(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    chk("t5_prg_state", 32'(state_out),  32'd0);
    chk("t5_prg_main",  32'(main_light), 32'h1);
    run_cycle(1'b1, 1'b0, 1'b0, 2'b11, 1'b0);
    reached = 1'b0;
    for (int c = 0; c < 60; c++) begin
      run_cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      if (state_out == 3'd5) begin reached = 1'b1; break; end
    end
    chk("t5_reach_sg", 32'(reached), 32'd1);
    chk("t5_first_grant", 32'(serving_side), 32'd0);
    repeat (40) run_cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);

    // 6: tick_en low during M_YEL freezes the phase
    run_cycle(1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
    reached = 1'b0;
    for (int c = 0; c < 60; c++) begin
      run_cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      if (state_out == 3'd2) begin reached = 1'b1; break; end
    end
    chk("t6_reach_m_yel", 32'(reached), 32'd1);
    for (int c = 0; c < 20; c++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
      chk("t6_frozen", 32'(state_out), 32'd2);
    end
    repeat (40) run_cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);

    // Random traffic
    for (int c = 0; c < 500; c++) begin
      logic tk, prg, ms, wb;
      logic [N_SIDE-1:0] ss;
      tk  = ($urandom_range(0, 3) != 0);
      prg = ($urandom_range(0, 79) == 0);
      ms  = 1'($urandom_range(0, 1));
      ss  = ($urandom_range(0, 9) == 0) ? N_SIDE'($urandom_range(0, 3)) : '0;
      wb  = ($urandom_range(0, 29) == 0);
      run_cycle(tk, prg, ms, ss, wb);
    end

    // Asynchronous reset in the middle of a side green
    reached = 1'b0;
    for (int c = 0; c < 120; c++) begin
      run_cycle(1'b1, 1'b0, 1'b0, 2'b11, 1'b0);
      if (state_out == 3'd5 || state_out == 3'd6) begin reached = 1'b1; break; end
    end
    chk("ar_reach_sg", 32'(reached), 32'd1);
    #3 sys_reset_n = 1'b0;
    #1;
    chk("ar_state", 32'(state_out),    32'd0);
    chk("ar_main",  32'(main_light),   32'h1);
    chk("ar_side",  32'(side_light),   32'h24);
    chk("ar_serve", 32'(serving_side), 32'd0);
    model_reset();
    @(negedge clk);
    sys_reset_n = 1'b1;
    repeat (30) run_cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
